// File: rtl/fuzzy_pkg.sv
// rtl/fuzzy_pkg.sv - shared set indices, default breakpoints, weights and FSM states
package fuzzy_pkg;

    localparam logic [2:0] RAW_L = 3'd0;
    localparam logic [2:0] RAW_M = 3'd1;
    localparam logic [2:0] RAW_H = 3'd2;
    localparam logic [2:0] SOW_L = 3'd3;
    localparam logic [2:0] SOW_M = 3'd4;
    localparam logic [2:0] SOW_H = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEMB,
        ST_RULE,
        ST_DEFUZ,
        ST_DONE
    } state_e;

    // 8-bit {a,b,c}; wider instances shift each value left by W-8
    function automatic logic [23:0] def_bp8(input logic [2:0] idx);
        case (idx)
            RAW_L, SOW_L: return {8'd0, 8'd20, 8'd40};
            RAW_M, SOW_M: return {8'd30, 8'd50, 8'd70};
            default:      return {8'd60, 8'd80, 8'd100};
        endcase
    endfunction

    function automatic logic [63:0] weight_h(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] weight_m(input int w);
        return (64'd2 * weight_h(w)) / 64'd3;
    endfunction

    function automatic logic [63:0] weight_l(input int w);
        return weight_h(w) / 64'd3;
    endfunction

endpackage

// File: rtl/seq_div.sv
// rtl/seq_div.sv - fixed-latency restoring divider: load, QW iterations, writeback
module seq_div #(
    parameter int NW = 18,
    parameter int DW = 10,
    parameter int QW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [NW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [QW-1:0] quotient_o
);
    localparam int CW = $clog2(QW + 1);

    logic [DW-1:0] rem_q, dvs_q;
    logic [QW-1:0] lo_q, quo_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q, done_q;
    logic [DW:0]   trial;
    logic          fits;

    // Caller guarantees dividend < divisor * 2^QW, so the upper part starts below the divisor
    always_comb begin
        trial = {rem_q, lo_q[QW-1]};
        fits  = trial >= {1'b0, dvs_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            lo_q   <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start_i) begin
                    rem_q  <= dividend_i[QW+DW-1:QW];
                    lo_q   <= dividend_i[QW-1:0];
                    dvs_q  <= divisor_i;
                    cnt_q  <= '0;
                    busy_q <= 1'b1;
                end
            end else if (cnt_q != CW'(QW)) begin
                rem_q <= fits ? DW'(trial - {1'b0, dvs_q}) : trial[DW-1:0];
                lo_q  <= {lo_q[QW-2:0], fits};
                cnt_q <= cnt_q + 1'b1;
            end else begin
                quo_q  <= lo_q;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/fuzzy_risk_seq.sv
// rtl/fuzzy_risk_seq.sv - sequential fuzzy flood-risk estimator with shared divider
module fuzzy_risk_seq
    import fuzzy_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   raw,
    input  logic [W-1:0]   sow,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   risk,
    input  logic           cfg_we,
    input  logic [2:0]     cfg_addr,
    input  logic [3*W-1:0] cfg_data,
    output logic           cfg_err,
    input  logic           cfg_clr
);
    localparam int NW = 2 * W + 2;
    localparam int DW = W + 2;
    localparam logic [W-1:0] WH = W'(weight_h(W));
    localparam logic [W-1:0] WM = W'(weight_m(W));
    localparam logic [W-1:0] WL = W'(weight_l(W));

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
    } bp_t;

    function automatic bp_t bp_default(input logic [2:0] idx);
        logic [23:0] d8;
        bp_t         bp;
        d8   = def_bp8(idx);
        bp.a = W'(d8[23:16]) << (W - 8);
        bp.b = W'(d8[15:8]) << (W - 8);
        bp.c = W'(d8[7:0]) << (W - 8);
        return bp;
    endfunction

    state_e        state_q;
    bp_t           bp_q [6];
    logic [W-1:0]  mem_q [6];
    logic [W-1:0]  raw_q, sow_q, risk_q;
    logic [2:0]    idx_q, pend_addr_q;
    bp_t           pend_data_q;
    logic          zero_q, cfg_err_q, pend_q;

    bp_t           cfg_bp, op_bp;
    logic          accept, cfg_ok, cfg_bad;
    logic [2:0]    op_idx;
    logic [W-1:0]  op_v, r_h, r_m, r_l;
    logic          m_zero, div_start, div_zero, div_busy, div_done;
    logic [NW-1:0] m_dvd, num, div_dvd;
    logic [DW-1:0] m_dvs, den, div_dvs;
    logic [W-1:0]  div_q;

    assign cfg_bp  = cfg_data;
    assign accept  = in_valid && (state_q == ST_IDLE);
    assign cfg_ok  = cfg_we && (state_q == ST_IDLE) && (cfg_addr <= SOW_H)
                     && (cfg_bp.a <= cfg_bp.b) && (cfg_bp.b <= cfg_bp.c);
    assign cfg_bad = cfg_we && !cfg_ok;

    // While a quotient is being written back, the next division's operands are already needed
    always_comb begin
        op_idx = (div_done && idx_q != SOW_H) ? idx_q + 3'd1 : idx_q;
        op_bp  = bp_q[op_idx];
        op_v   = (op_idx < SOW_L) ? raw_q : sow_q;
        m_zero = (op_v <= op_bp.a) || (op_v > op_bp.c);
        if (op_v <= op_bp.b) begin
            m_dvd = {2'b00, op_v - op_bp.a, {W{1'b0}}} - NW'(1);
            m_dvs = {2'b00, op_bp.b - op_bp.a};
        end else begin
            m_dvd = {2'b00, op_bp.c - op_v, {W{1'b0}}} - NW'(1);
            m_dvs = {2'b00, op_bp.c - op_bp.b};
        end
        if (m_zero) begin
            m_dvd = '0;
            m_dvs = DW'(1);
        end
    end

    always_comb begin
        r_h = (mem_q[RAW_H] < mem_q[SOW_H]) ? mem_q[RAW_H] : mem_q[SOW_H];
        r_m = (mem_q[RAW_M] < mem_q[SOW_M]) ? mem_q[RAW_M] : mem_q[SOW_M];
        r_l = (mem_q[RAW_L] < mem_q[SOW_L]) ? mem_q[RAW_L] : mem_q[SOW_L];
        num = NW'(r_h) * NW'(WH) + NW'(r_m) * NW'(WM) + NW'(r_l) * NW'(WL);
        den = DW'(r_h) + DW'(r_m) + DW'(r_l);
    end

    // The defuzzification divide is launched from RULE so it lines up with the membership slots
    always_comb begin
        div_start = 1'b0;
        div_dvd   = m_dvd;
        div_dvs   = m_dvs;
        div_zero  = m_zero;
        case (state_q)
            ST_MEMB: div_start = !div_busy && !(div_done && idx_q == SOW_H);
            ST_RULE: begin
                div_start = 1'b1;
                div_dvd   = num;
                div_zero  = (den == '0);
                div_dvs   = (den == '0) ? DW'(1) : den;
            end
            default: ;
        endcase
    end

    seq_div #(.NW(NW), .DW(DW), .QW(W)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i (div_dvd),
        .divisor_i  (div_dvs),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            raw_q       <= '0;
            sow_q       <= '0;
            risk_q      <= '0;
            idx_q       <= '0;
            zero_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            for (int i = 0; i < 6; i++) begin
                bp_q[i]  <= bp_default(3'(i));
                mem_q[i] <= '0;
            end
        end else begin
            if (cfg_bad)
                cfg_err_q <= 1'b1;
            else if (cfg_clr)
                cfg_err_q <= 1'b0;

            // A write that lands with a sample acceptance is parked until that sample completes
            if (cfg_ok && !accept)
                bp_q[cfg_addr] <= cfg_bp;
            if (cfg_ok && accept) begin
                pend_q      <= 1'b1;
                pend_addr_q <= cfg_addr;
                pend_data_q <= cfg_bp;
            end

            if (div_start)
                zero_q <= div_zero;

            case (state_q)
                ST_IDLE: if (in_valid) begin
                    raw_q   <= raw;
                    sow_q   <= sow;
                    idx_q   <= '0;
                    state_q <= ST_MEMB;
                end
                ST_MEMB: if (div_done) begin
                    mem_q[idx_q] <= zero_q ? '0 : div_q;
                    if (idx_q == SOW_H)
                        state_q <= ST_RULE;
                    else
                        idx_q <= idx_q + 3'd1;
                end
                ST_RULE: state_q <= ST_DEFUZ;
                ST_DEFUZ: if (div_done) begin
                    risk_q  <= zero_q ? '0 : div_q;
                    state_q <= ST_DONE;
                end
                ST_DONE: if (out_ready) begin
                    state_q <= ST_IDLE;
                    if (pend_q) begin
                        bp_q[pend_addr_q] <= pend_data_q;
                        pend_q            <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign risk      = risk_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fuzzy_risk_seq.sv
// tb/tb_fuzzy_risk_seq.sv - randomized self-checking bench with arithmetic reference model
module tb_fuzzy_risk_seq;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   raw;
    logic [W-1:0]   sow;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   risk;
    logic           cfg_we;
    logic [2:0]     cfg_addr;
    logic [3*W-1:0] cfg_data;
    logic           cfg_err;
    logic           cfg_clr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int bpa [6];
    int bpb [6];
    int bpc [6];

    fuzzy_risk_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .raw       (raw),
        .sow       (sow),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .risk      (risk),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .cfg_clr   (cfg_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_defaults();
        for (int i = 0; i < 6; i++) begin
            case (i % 3)
                0: begin bpa[i] = 0;  bpb[i] = 20; bpc[i] = 40;  end
                1: begin bpa[i] = 30; bpb[i] = 50; bpc[i] = 70;  end
                default: begin bpa[i] = 60; bpb[i] = 80; bpc[i] = 100; end
            endcase
        end
    endfunction

    function automatic int memb(int v, int a, int b, int c);
        if (v <= a || v > c) return 0;
        if (v <= b) return ((v - a) * 256 - 1) / (b - a);
        return ((c - v) * 256 - 1) / (c - b);
    endfunction

    function automatic int imin(int x, int y);
        return (x < y) ? x : y;
    endfunction

    function automatic int model_risk(int r, int s);
        int m [6];
        int rh, rm, rl, den;
        for (int i = 0; i < 6; i++)
            m[i] = memb((i < 3) ? r : s, bpa[i], bpb[i], bpc[i]);
        rh  = imin(m[2], m[5]);
        rm  = imin(m[1], m[4]);
        rl  = imin(m[0], m[3]);
        den = rh + rm + rl;
        if (den == 0) return 0;
        return (rh * 255 + rm * 170 + rl * 85) / den;
    endfunction

    task automatic cfg_write(input int addr, input int a, input int b, input int c, input bit clr);
        cfg_we   = 1'b1;
        cfg_addr = 3'(addr);
        cfg_data = {8'(a), 8'(b), 8'(c)};
        cfg_clr  = clr;
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        cfg_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_err();
        cfg_clr = 1'b1;
        @(posedge clk);
        #1;
        cfg_clr = 1'b0;
        chk("cfg_clr", cfg_err, 0);
        @(negedge clk);
    endtask

    task automatic start_sample(input int r, input int s, input bit wr, input int addr,
                                input int a, input int b, input int c);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        raw      = 8'(r);
        sow      = 8'(s);
        in_valid = 1'b1;
        if (wr) begin
            cfg_we   = 1'b1;
            cfg_addr = 3'(addr);
            cfg_data = {8'(a), 8'(b), 8'(c)};
        end
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic finish_sample(input string tag, input int exp, input int hold);
        int n = 0;
        while (!out_valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, cyc - acc_cyc, 72);
        chk({tag, "_risk"}, risk, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            raw      = 8'($urandom_range(0, 255));
            sow      = 8'($urandom_range(0, 255));
            chk("hold_valid", out_valid, 1);
            chk("hold_risk", risk, exp);
            chk("hold_in_ready", in_ready, 0);
        end
        if (hold > 0) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_exit_valid"}, out_valid, 0);
        chk({tag, "_exit_ready"}, in_ready, 1);
        @(negedge clk);
    endtask

    task automatic run(input string tag, input int r, input int s, input int exp);
        start_sample(r, s, 1'b0, 0, 0, 0, 0);
        finish_sample(tag, exp, 0);
    endtask

    initial begin
        int a, b, c, t, r, s, addr;
        rst_n = 1'b0; in_valid = 1'b0; raw = '0; sow = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_clr = 1'b0;
        model_defaults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_risk", risk, 0);
        chk("rst_cfg_err", cfg_err, 0);

        run("def_80", 80, 80, 255);
        run("def_50", 50, 50, 170);
        run("def_20", 20, 20, 85);
        run("def_35", 35, 35, 127);
        run("def_200", 200, 200, 0);

        cfg_write(6, 10, 20, 30, 1'b0);
        chk("err_addr6", cfg_err, 1);
        clear_err();
        cfg_write(0, 50, 40, 60, 1'b0);
        chk("err_unordered", cfg_err, 1);
        cfg_write(7, 10, 20, 30, 1'b1);
        chk("err_set_beats_clr", cfg_err, 1);
        clear_err();
        start_sample(80, 80, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        cfg_write(2, 0, 0, 0, 1'b0);
        chk("err_busy", cfg_err, 1);
        finish_sample("busy_wr", 255, 0);
        run("after_err", 80, 80, 255);
        clear_err();

        cfg_write(2, 100, 150, 200, 1'b0);
        bpa[2] = 100; bpb[2] = 150; bpc[2] = 200;
        chk("good_wr_err", cfg_err, 0);
        run("cus_150_80", 150, 80, 255);
        run("cus_80_80", 80, 80, 0);
        chk("good_wr_err2", cfg_err, 0);

        start_sample(80, 80, 1'b1, 2, 60, 80, 100);
        finish_sample("coincide", 0, 0);
        bpa[2] = 60; bpb[2] = 80; bpc[2] = 100;
        run("coincide_next", 80, 80, 255);

        out_ready = 1'b0;
        start_sample(50, 50, 1'b0, 0, 0, 0, 0);
        finish_sample("backpressure", 170, 20);
        run("after_bp", 20, 20, 85);
        run("prime_risk", 50, 50, 170);

        cfg_write(2, 100, 150, 200, 1'b0);
        cfg_write(6, 1, 2, 3, 1'b0);
        start_sample(50, 50, 1'b0, 0, 0, 0, 0);
        repeat (66) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_risk", risk, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_cfg_err", cfg_err, 0);
        @(negedge clk);
        model_defaults();
        run("after_rst", 80, 80, 255);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
                c = $urandom_range(0, 255);
                if (a > b) begin t = a; a = b; b = t; end
                if (b > c) begin t = b; b = c; c = t; end
                if (a > b) begin t = a; a = b; b = t; end
                addr = $urandom_range(0, 5);
                cfg_write(addr, a, b, c, 1'b0);
                bpa[addr] = a; bpb[addr] = b; bpc[addr] = c;
                chk("rand_cfg_err", cfg_err, 0);
            end
            r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 120);
            s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 120);
            run("rand", r, s, model_risk(r, s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
